valu_decoupled_wrapper: RTL and testbench

//  Per-lane VALU front end. Queues up to ReqBufDepth VALU requests from vinsn_launcher and

---
 rtl/valu_decoupled_wrapper.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_valu_decoupled_wrapper.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/valu_decoupled_wrapper.sv
// Per-lane VALU front end: request queue, operand/result FIFOs, decoupled issue and commit.
// Optional per-byte write masking (mask FIFO + ports) is compiled in with `define VALU_MASK_EN.

module valu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk_i) if (w_push) r_mem[r_wr] <= i_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr <= '0; r_rd <= '0; r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

module valu_decoupled_wrapper #(
    parameter int LaneId        = 0,
    parameter int NrOperands    = 2,
    parameter int ReqBufDepth   = 2,
    parameter int ALUOpBufDepth = 4,
    parameter int ALUWBufDepth  = 2,
    parameter int NrLanes       = 4,
    parameter int ReqW          = 3 + 3 + 2 + NrOperands + 1 + 64 + 16 + 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         vfu_req_valid_i,
    output logic                         vfu_req_ready_o,
    input  logic [ReqW-1:0]              vfu_req_i,
    input  logic [1:0]                   target_vfu_i,
    output logic                         alu_done_o,
    output logic [2:0]                   alu_done_id_o,
    input  logic                         alu_done_gnt_i,
    input  logic [NrOperands-1:0]        op_valid_i,
    output logic [NrOperands-1:0]        op_ready_o,
    input  logic [NrOperands-1:0][63:0]  alu_op_i,
`ifdef VALU_MASK_EN
    input  logic                         mask_valid_i,
    output logic                         mask_ready_o,
    input  logic [7:0]                   mask_i,
`endif
    output logic [63:0]                  alu_result_wdata_o,
    output logic [7:0]                   alu_result_wstrb_o,
    output logic [7:0]                   alu_result_addr_o,
    output logic [2:0]                   alu_result_id_o,
    output logic                         alu_result_valid_o,
    input  logic                         alu_result_gnt_i
);
    localparam logic [1:0]  VfuValu = 2'd1;
    localparam int          LogNrLanes = $clog2(NrLanes);
    localparam int          QPW = (ReqBufDepth > 1) ? $clog2(ReqBufDepth) : 1;
    localparam int          QCW = $clog2(ReqBufDepth + 1);
    localparam logic [15:0] WordB = 16'd8;
    localparam logic [2:0]  OpSub = 3'd1, OpAnd = 3'd2, OpOr = 3'd3, OpXor = 3'd4, OpAdd3 = 3'd5;

    typedef struct packed {
        logic [2:0]            id;
        logic [2:0]            op;
        logic [1:0]            vew;
        logic [NrOperands-1:0] use_vs;
        logic                  vm;
        logic [63:0]           scalar;
        logic [15:0]           vl;
        logic [7:0]            waddr;
    } req_t;

    typedef enum logic [1:0] {SIdle, SCommit, SDone} state_e;

    // Byte-sliced add/sub; the carry chain restarts at every element boundary of width vew.
    function automatic logic [63:0] f_addsub(input logic [63:0] a, input logic [63:0] b,
                                             input logic sub, input logic [1:0] vew);
        logic [63:0] r;
        logic [8:0]  s;
        logic        cy;
        r  = '0;
        cy = sub;
        for (int k = 0; k < 8; k++) begin
            if ((3'(k) & ((3'd1 << vew) - 3'd1)) == 3'd0) cy = sub;
            s = {1'b0, a[8*k+:8]} + {1'b0, b[8*k+:8] ^ {8{sub}}} + {8'd0, cy};
            r[8*k+:8] = s[7:0];
            cy = s[8];
        end
        return r;
    endfunction

    function automatic logic [QPW-1:0] f_qinc(input logic [QPW-1:0] p);
        return (p == QPW'(ReqBufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    req_t                        r_req [ReqBufDepth];
    logic [QPW-1:0]              r_wptr, r_head, r_iss_ptr;
    logic [QCW-1:0]              r_cnt, r_iss_cnt;
    logic [15:0]                 r_iss_rem, r_commit_rem;
    logic                        r_iss_loaded;
    logic [7:0]                  r_waddr;
    state_e                      r_state, w_state_nxt;

    req_t                        w_in, w_iss;
    logic                        w_push, w_head_pop, w_head_vld, w_next_vld, w_wr_fire;
    logic [15:0]                 w_iss_rem, w_iss_rem_nxt, w_head_vl, w_next_vl;
    logic                        w_iss_vld, w_fire, w_iss_adv, w_ops_ok, w_mask_ok;
    logic [NrOperands-1:0]       w_need, w_op_empty, w_op_full;
    logic [NrOperands-1:0][63:0] w_op_data;
    logic [63:0]                 w_scal, w_a, w_c, w_res;
    logic [7:0]                  w_strb, w_mask_and;
    logic                        w_res_full, w_res_empty;
    logic                        w_unused;

    // ---------------- request queue ----------------
    always_comb begin
        w_in    = vfu_req_i;
        w_in.vl = w_in.vl >> LogNrLanes;
    end
    assign vfu_req_ready_o = (r_cnt != QCW'(ReqBufDepth));
    assign w_push     = vfu_req_valid_i & vfu_req_ready_o & (target_vfu_i == VfuValu);
    assign w_head_pop = alu_done_o & alu_done_gnt_i;
    assign w_head_vld = (r_cnt != '0);
    assign w_next_vld = (r_cnt > QCW'(1));
    assign w_head_vl  = r_req[r_head].vl;
    assign w_next_vl  = r_req[f_qinc(r_head)].vl;

    always_ff @(posedge clk_i) if (w_push) r_req[r_wptr] <= w_in;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0; r_head <= '0; r_cnt <= '0;
        end else begin
            if (w_push)     r_wptr <= f_qinc(r_wptr);
            if (w_head_pop) r_head <= f_qinc(r_head);
            if (w_push && !w_head_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_head_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    // ---------------- operand FIFOs and issue ----------------
    genvar g;
    generate
        for (g = 0; g < NrOperands; g++) begin : g_op
            valu_fifo #(.DEPTH(ALUOpBufDepth), .W(64)) u_op (
                .clk_i(clk_i), .rst_i(rst_i), .i_push(op_valid_i[g]), .i_pop(w_fire & w_need[g]),
                .i_data(alu_op_i[g]), .o_data(w_op_data[g]), .o_full(w_op_full[g]),
                .o_empty(w_op_empty[g]));
        end
        if (NrOperands > 2) begin : g_c
            assign w_c = w_op_data[2];
        end else begin : g_noc
            assign w_c = '0;
        end
    endgenerate
    assign op_ready_o = ~w_op_full;

    assign w_iss     = r_req[r_iss_ptr];
    assign w_iss_vld = (r_iss_cnt != '0);
    assign w_iss_rem = r_iss_loaded ? r_iss_rem : w_iss.vl;
    always_comb begin
        w_need    = w_iss.use_vs;
        w_need[1] = 1'b1;
    end
    assign w_ops_ok      = &(~w_need | ~w_op_empty);
    assign w_fire        = w_iss_vld & w_ops_ok & ~w_res_full & w_mask_ok & (w_iss_rem != '0);
    assign w_iss_adv     = w_iss_vld & ((w_iss_rem == '0) | (w_fire & (w_iss_rem <= WordB)));
    assign w_iss_rem_nxt = (w_iss_rem > WordB) ? w_iss_rem - WordB : '0;

    always_comb begin
        unique case (w_iss.vew)
            2'd0:    w_scal = {8{w_iss.scalar[7:0]}};
            2'd1:    w_scal = {4{w_iss.scalar[15:0]}};
            2'd2:    w_scal = {2{w_iss.scalar[31:0]}};
            default: w_scal = w_iss.scalar;
        endcase
        w_a = w_iss.use_vs[0] ? w_op_data[0] : w_scal;
        case (w_iss.op)
            OpSub:   w_res = f_addsub(w_a, w_op_data[1], 1'b1, w_iss.vew);
            OpAnd:   w_res = w_a & w_op_data[1];
            OpOr:    w_res = w_a | w_op_data[1];
            OpXor:   w_res = w_a ^ w_op_data[1];
            OpAdd3:  w_res = f_addsub(f_addsub(w_a, w_op_data[1], 1'b0, w_iss.vew), w_c, 1'b0, w_iss.vew);
            default: w_res = f_addsub(w_a, w_op_data[1], 1'b0, w_iss.vew);
        endcase
        w_strb = (w_iss_rem >= WordB) ? 8'hFF : ((8'd1 << w_iss_rem[2:0]) - 8'd1);
        w_strb = w_strb & w_mask_and;
    end

`ifdef VALU_MASK_EN
    logic [7:0] w_mask;
    logic       w_mask_full, w_mask_empty;
    valu_fifo #(.DEPTH(ALUOpBufDepth), .W(8)) u_mask (
        .clk_i(clk_i), .rst_i(rst_i), .i_push(mask_valid_i), .i_pop(w_fire & ~w_iss.vm),
        .i_data(mask_i), .o_data(w_mask), .o_full(w_mask_full), .o_empty(w_mask_empty));
    assign mask_ready_o = ~w_mask_full;
    assign w_mask_ok    = w_iss.vm | ~w_mask_empty;
    assign w_mask_and   = w_iss.vm ? 8'hFF : w_mask;
    assign w_unused     = ^{w_iss.id, w_iss.waddr, 32'(LaneId)};
`else
    assign w_mask_ok  = 1'b1;
    assign w_mask_and = 8'hFF;
    assign w_unused   = ^{w_iss.id, w_iss.waddr, w_iss.vm, 32'(LaneId)};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_iss_ptr <= '0; r_iss_cnt <= '0; r_iss_rem <= '0; r_iss_loaded <= 1'b0;
        end else begin
            if (w_iss_adv) begin
                r_iss_ptr    <= f_qinc(r_iss_ptr);
                r_iss_loaded <= 1'b0;
            end else if (w_fire) begin
                r_iss_rem    <= w_iss_rem_nxt;
                r_iss_loaded <= 1'b1;
            end
            if (w_push && !w_iss_adv)      r_iss_cnt <= r_iss_cnt + 1'b1;
            else if (w_iss_adv && !w_push) r_iss_cnt <= r_iss_cnt - 1'b1;
        end
    end

    valu_fifo #(.DEPTH(ALUWBufDepth), .W(72)) u_res (
        .clk_i(clk_i), .rst_i(rst_i), .i_push(w_fire), .i_pop(w_wr_fire),
        .i_data({w_res, w_strb}), .o_data({alu_result_wdata_o, alu_result_wstrb_o}),
        .o_full(w_res_full), .o_empty(w_res_empty));

    // ---------------- commit FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= SIdle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SIdle:   if (w_head_vld) w_state_nxt = (w_head_vl == '0) ? SDone : SCommit;
            SCommit: if (w_wr_fire && r_commit_rem <= WordB) w_state_nxt = SDone;
            SDone:   if (alu_done_gnt_i)
                         w_state_nxt = (w_next_vld && w_next_vl != '0) ? SCommit : SIdle;
            default: w_state_nxt = SIdle;
        endcase
    end

    always_comb begin
        alu_result_valid_o = (r_state == SCommit) && !w_res_empty;
        alu_done_o         = (r_state == SDone);
    end

    assign w_wr_fire         = alu_result_valid_o & alu_result_gnt_i;
    assign alu_result_addr_o = r_waddr;
    assign alu_result_id_o   = r_req[r_head].id;
    assign alu_done_id_o     = r_req[r_head].id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_commit_rem <= '0; r_waddr <= '0;
        end else if (r_state == SIdle && w_head_vld) begin
            r_commit_rem <= w_head_vl;
            r_waddr      <= r_req[r_head].waddr;
        end else if (w_wr_fire) begin
            r_commit_rem <= (r_commit_rem > WordB) ? r_commit_rem - WordB : '0;
            r_waddr      <= r_waddr + 8'd1;
        end else if (w_head_pop && w_next_vld) begin
            r_commit_rem <= w_next_vl;
            r_waddr      <= r_req[f_qinc(r_head)].waddr;
        end
    end
endmodule

// File: tb/tb_valu_decoupled_wrapper.sv
// Directed bench for valu_decoupled_wrapper: hand-computed write data/strobes, done handshake,
// queue-full, scalar operand, zero-length and reset cases; mask cases when VALU_MASK_EN is set.
module tb_valu_decoupled_wrapper;
    logic             clk_i = 0;
    logic             rst_i = 1;
    logic             vfu_req_valid_i = 0;
    logic             vfu_req_ready_o;
    logic [98:0]      vfu_req_i = '0;
    logic [1:0]       target_vfu_i = '0;
    logic             alu_done_o;
    logic [2:0]       alu_done_id_o;
    logic             alu_done_gnt_i = 0;
    logic [1:0]       op_valid_i = '0;
    logic [1:0]       op_ready_o;
    logic [1:0][63:0] alu_op_i = '0;
    logic [63:0]      alu_result_wdata_o;
    logic [7:0]       alu_result_wstrb_o;
    logic [7:0]       alu_result_addr_o;
    logic [2:0]       alu_result_id_o;
    logic             alu_result_valid_o;
    logic             alu_result_gnt_i = 0;
`ifdef VALU_MASK_EN
    logic             mask_valid_i = 0;
    logic             mask_ready_o;
    logic [7:0]       mask_i = '0;
`endif

    int errors = 0;
    int checks = 0;

    valu_decoupled_wrapper dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .vfu_req_valid_i(vfu_req_valid_i), .vfu_req_ready_o(vfu_req_ready_o),
        .vfu_req_i(vfu_req_i), .target_vfu_i(target_vfu_i),
        .alu_done_o(alu_done_o), .alu_done_id_o(alu_done_id_o), .alu_done_gnt_i(alu_done_gnt_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .alu_op_i(alu_op_i),
`ifdef VALU_MASK_EN
        .mask_valid_i(mask_valid_i), .mask_ready_o(mask_ready_o), .mask_i(mask_i),
`endif
        .alu_result_wdata_o(alu_result_wdata_o), .alu_result_wstrb_o(alu_result_wstrb_o),
        .alu_result_addr_o(alu_result_addr_o), .alu_result_id_o(alu_result_id_o),
        .alu_result_valid_o(alu_result_valid_o), .alu_result_gnt_i(alu_result_gnt_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    function automatic logic [98:0] mk(input logic [2:0] id, input logic [2:0] op,
                                       input logic [1:0] vew, input logic [1:0] use_vs,
                                       input logic vm, input logic [63:0] sc,
                                       input logic [15:0] vl, input logic [7:0] wa);
        return {id, op, vew, use_vs, vm, sc, vl, wa};
    endfunction

    task automatic send_req(input logic [1:0] tgt, input logic [98:0] req);
        int n = 0;
        vfu_req_i = req; target_vfu_i = tgt; vfu_req_valid_i = 1;
        while (!vfu_req_ready_o && n < 50) begin step(); n++; end
        if (n == 50) chk("req accept timeout", 64'd0, 64'd1);
        step();
        vfu_req_valid_i = 0;
    endtask

    task automatic push_ops(input logic [1:0] vld, input logic [63:0] a, input logic [63:0] b);
        op_valid_i = vld; alu_op_i[0] = a; alu_op_i[1] = b;
        step();
        op_valid_i = '0;
    endtask

    task automatic exp_wr(input string tag, input logic [7:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic [2:0] id);
        int n = 0;
        while (!alu_result_valid_o && n < 50) begin step(); n++; end
        chk({tag, " valid"}, 64'(alu_result_valid_o), 64'd1);
        chk({tag, " addr"},  64'(alu_result_addr_o), 64'(addr));
        chk({tag, " data"},  alu_result_wdata_o, data);
        chk({tag, " strb"},  64'(alu_result_wstrb_o), 64'(strb));
        chk({tag, " id"},    64'(alu_result_id_o), 64'(id));
        alu_result_gnt_i = 1;
        step();
        alu_result_gnt_i = 0;
    endtask

    task automatic exp_done(input string tag, input logic [2:0] id);
        int n = 0;
        while (!alu_done_o && n < 50) begin step(); n++; end
        chk({tag, " done"},    64'(alu_done_o), 64'd1);
        chk({tag, " done id"}, 64'(alu_done_id_o), 64'(id));
        alu_done_gnt_i = 1;
        step();
        alu_done_gnt_i = 0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst ready",    64'(vfu_req_ready_o), 64'd1);
        chk("rst op_ready", 64'(op_ready_o), 64'd3);
        chk("rst valid",    64'(alu_result_valid_o), 64'd0);
        chk("rst done",     64'(alu_done_o), 64'd0);
        step(); step();
        rst_i = 0;
        step();

        // Request aimed at another unit is ignored
        send_req(2'd2, mk(3'd7, 3'd0, 2'd3, 2'b11, 1'b1, 64'd0, 16'd0, 8'h00));
        step(); step(); step();
        chk("foreign done",  64'(alu_done_o), 64'd0);
        chk("foreign valid", 64'(alu_result_valid_o), 64'd0);

        // 1: vadd EW32, vlB=64 -> 16B/lane, two full words
        push_ops(2'b11, 64'h00000001_00000002, 64'h00000003_FFFFFFFF);
        push_ops(2'b11, 64'h11111111_22222222, 64'h01010101_02020202);
        send_req(2'd1, mk(3'd1, 3'd0, 2'd2, 2'b11, 1'b1, 64'd0, 16'd64, 8'h10));
        exp_wr("t1 w0", 8'h10, 64'h00000004_00000001, 8'hFF, 3'd1);
        exp_wr("t1 w1", 8'h11, 64'h12121212_24242424, 8'hFF, 3'd1);
        exp_done("t1", 3'd1);

        // 2: vsub EW8, vlB=44 -> 11B/lane, tail strobe 0x07, address wraps
        push_ops(2'b11, 64'h01020304_05060708, 64'h01010101_01010101);
        push_ops(2'b11, 64'h10101010_10101000, 64'h01010101_01010101);
        send_req(2'd1, mk(3'd2, 3'd1, 2'd0, 2'b11, 1'b1, 64'd0, 16'd44, 8'hFF));
        exp_wr("t2 w0", 8'hFF, 64'h00010203_04050607, 8'hFF, 3'd2);
        chk("t2 no early done", 64'(alu_done_o), 64'd0);
        exp_wr("t2 w1", 8'h00, 64'h0F0F0F0F_0F0F0FFF, 8'h07, 3'd2);
        chk("t2 done after gnt", 64'(alu_done_o), 64'd1);
        exp_done("t2", 3'd2);

        // 3: two back-to-back requests, done grant withheld
        push_ops(2'b11, 64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00);
        push_ops(2'b11, 64'hAAAAAAAA_AAAAAAAA, 64'hFFFFFFFF_FFFFFFFF);
        send_req(2'd1, mk(3'd3, 3'd2, 2'd3, 2'b11, 1'b1, 64'd0, 16'd32, 8'h20));
        send_req(2'd1, mk(3'd4, 3'd4, 2'd3, 2'b11, 1'b1, 64'd0, 16'd32, 8'h30));
        chk("t3 queue full", 64'(vfu_req_ready_o), 64'd0);
        exp_wr("t3 a", 8'h20, 64'hF000F000_F000F000, 8'hFF, 3'd3);
        for (int i = 0; i < 5; i++) begin
            chk("t3 held valid", 64'(alu_result_valid_o), 64'd0);
            chk("t3 held done",  64'(alu_done_o), 64'd1);
            step();
        end
        alu_done_gnt_i = 1;
        step();
        alu_done_gnt_i = 0;
        chk("t3 b already issued", 64'(alu_result_valid_o), 64'd1);
        exp_wr("t3 b", 8'h30, 64'h55555555_55555555, 8'hFF, 3'd4);
        exp_done("t3 b", 3'd4);

        // 4: scalar ch0 (EW8 0x5A), ch0 FIFO must keep its sentinel
        push_ops(2'b01, 64'hDEADBEEF_CAFEF00D, 64'd0);
        push_ops(2'b10, 64'd0, 64'h00010203_04050607);
        send_req(2'd1, mk(3'd5, 3'd0, 2'd0, 2'b10, 1'b1, 64'h5A, 16'd32, 8'h40));
        exp_wr("t4 vx", 8'h40, 64'h5A5B5C5D_5E5F6061, 8'hFF, 3'd5);
        exp_done("t4 vx", 3'd5);
        push_ops(2'b10, 64'd0, 64'd0);
        send_req(2'd1, mk(3'd1, 3'd3, 2'd3, 2'b11, 1'b1, 64'd0, 16'd32, 8'h41));
        exp_wr("t4 ch0 kept", 8'h41, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3'd1);
        exp_done("t4 ch0 kept", 3'd1);

        // 5a: zero-length request: no writes, done one cycle later
        send_req(2'd1, mk(3'd6, 3'd0, 2'd3, 2'b11, 1'b1, 64'd0, 16'd0, 8'h50));
        chk("t5 done not yet", 64'(alu_done_o), 64'd0);
        step();
        chk("t5 done",    64'(alu_done_o), 64'd1);
        chk("t5 done id", 64'(alu_done_id_o), 64'd6);
        chk("t5 no write", 64'(alu_result_valid_o), 64'd0);
        alu_done_gnt_i = 1;
        step();
        alu_done_gnt_i = 0;
        chk("t5 done dropped", 64'(alu_done_o), 64'd0);

        // 5b: reset during COMMIT with a full ch0 operand FIFO
        push_ops(2'b11, 64'd1, 64'd1);
        push_ops(2'b11, 64'd2, 64'd2);
        send_req(2'd1, mk(3'd7, 3'd0, 2'd3, 2'b11, 1'b1, 64'd0, 16'd64, 8'h60));
        begin
            int n = 0;
            while (!alu_result_valid_o && n < 50) begin step(); n++; end
        end
        chk("t5 commit valid", 64'(alu_result_valid_o), 64'd1);
        for (int i = 0; i < 4; i++) push_ops(2'b01, 64'(i), 64'd0);
        chk("t5 ch0 full", 64'(op_ready_o), 64'd2);
        rst_i = 1;
        #2;
        chk("t5 rst valid",    64'(alu_result_valid_o), 64'd0);
        chk("t5 rst done",     64'(alu_done_o), 64'd0);
        chk("t5 rst ready",    64'(vfu_req_ready_o), 64'd1);
        chk("t5 rst op_ready", 64'(op_ready_o), 64'd3);
        step();
        rst_i = 0;
        step(); step(); step(); step();
        chk("t5 post rst valid", 64'(alu_result_valid_o), 64'd0);
        chk("t5 post rst done",  64'(alu_done_o), 64'd0);

`ifdef VALU_MASK_EN
        // 6: vm=1 ignores the mask FIFO, vm=0 consumes it
        mask_i = 8'h0F; mask_valid_i = 1;
        step();
        mask_valid_i = 0;
        push_ops(2'b11, 64'd1, 64'd2);
        push_ops(2'b11, 64'd5, 64'd5);
        send_req(2'd1, mk(3'd2, 3'd0, 2'd3, 2'b11, 1'b1, 64'd0, 16'd32, 8'h70));
        exp_wr("t6 vm1", 8'h70, 64'd3, 8'hFF, 3'd2);
        exp_done("t6 vm1", 3'd2);
        send_req(2'd1, mk(3'd3, 3'd0, 2'd3, 2'b11, 1'b0, 64'd0, 16'd32, 8'h71));
        exp_wr("t6 vm0", 8'h71, 64'hA, 8'h0F, 3'd3);
        exp_done("t6 vm0", 3'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
